// File: rtl/morse_symbol_capture.sv
// Morse key capture: times key presses in prescaled ticks, classifies each press
// as dot or dash, and assembles up to five symbols into a committed letter code.
module morse_symbol_capture #(
    parameter int TICK_DIV = 5000,
    parameter int DOT_MAX  = 2000,
    parameter int DASH_MIN = 4000,
    parameter int DASH_MAX = 7000,
    parameter int GAP_MIN  = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press,
    input  logic       del_pulse,
    input  logic       fin_pulse,
    input  logic       letter_ready,
    output logic [9:0] letter_code,
    output logic       letter_valid,
    output logic [2:0] sym_count,
    output logic [1:0] last_sym,
    output logic       overflow
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [16:0]   DUR_SAT    = 17'h1FFFF;
    localparam logic [16:0]   DOT_C      = 17'(DOT_MAX);
    localparam logic [16:0]   DASH_MIN_C = 17'(DASH_MIN);
    localparam logic [16:0]   DASH_MAX_C = 17'(DASH_MAX);
    localparam logic [16:0]   GAP_C      = 17'(GAP_MIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_presc;
    logic [16:0]   r_dur;
    logic          r_press_q;
    logic          r_armed;
    logic [2:0]    r_count;
    logic [1:0]    r_last;
    logic          r_ovf;

    logic       w_tick;
    logic       w_edge;
    logic       w_rise;
    logic       w_fall;
    logic [1:0] w_class;
    logic       w_release;
    logic       w_del;
    logic       w_clear;
    logic       w_store;
    logic       w_ovf_set;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_edge = press ^ r_press_q;
    // A key already down when reset releases must be seen low once before a rise counts.
    assign w_rise = press & ~r_press_q & r_armed;
    assign w_fall = ~press & r_press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_press_q <= 1'b0;
            r_armed   <= 1'b0;
            r_dur     <= '0;
        end else begin
            r_presc   <= w_tick ? '0 : r_presc + 1'b1;
            r_press_q <= press;
            r_armed   <= r_armed | ~press;
            if (w_edge)
                r_dur <= '0;
            else if (w_tick && r_dur != DUR_SAT)
                r_dur <= r_dur + 17'd1;
        end
    end

    always_comb begin
        w_class = 2'b00;
        if (r_dur >= 17'd1 && r_dur < DOT_C)
            w_class = 2'b10;
        else if (r_dur >= DASH_MIN_C && r_dur <= DASH_MAX_C)
            w_class = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_release    = 1'b0;
        w_del        = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise)
                    w_state_next = S_PRESS;
                else if (fin_pulse)
                    w_state_next = S_HOLD;
                else if (del_pulse && r_count != 3'd0)
                    w_del = 1'b1;
            end
            S_PRESS: begin
                if (w_fall) begin
                    w_release    = 1'b1;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                // Commit takes priority over a delete arriving in the same cycle.
                if (w_rise)
                    w_state_next = S_PRESS;
                else if (fin_pulse || r_dur >= GAP_C)
                    w_state_next = S_HOLD;
                else if (del_pulse && r_count != 3'd0)
                    w_del = 1'b1;
            end
            S_HOLD: begin
                if (letter_ready) begin
                    w_clear      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_store   = w_release && (w_class != 2'b00) && (r_count < 3'd5);
    assign w_ovf_set = w_release && (w_class != 2'b00) && (r_count == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_last  <= 2'b00;
            r_ovf   <= 1'b0;
        end else begin
            if (w_release)
                r_last <= w_class;
            if (w_clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_store) begin
                r_count <= r_count + 3'd1;
            end else if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_del) begin
                r_count <= r_count - 3'd1;
                r_ovf   <= 1'b0;
            end
        end
    end

    // Slot gi occupies letter_code[9-2gi -: 2]; first symbol lands in the top pair.
    for (genvar gi = 0; gi < 5; gi++) begin : g_slot
        logic [1:0] r_slot;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_slot <= 2'b00;
            else if (w_clear)
                r_slot <= 2'b00;
            else if (w_store && r_count == 3'(gi))
                r_slot <= w_class;
            else if (w_del && r_count == 3'(gi + 1))
                r_slot <= 2'b00;
        end
        assign letter_code[9-2*gi -: 2] = r_slot;
    end

    assign letter_valid = (r_state == S_HOLD);
    assign sym_count    = r_count;
    assign last_sym     = r_last;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Randomized bench for morse_symbol_capture against a queue-based letter model.
module tb_morse_symbol_capture;

    localparam int TICK_DIV = 4;
    localparam int DOT_MAX  = 20;
    localparam int DASH_MIN = 40;
    localparam int DASH_MAX = 70;
    localparam int GAP_MIN  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       press = 1'b0;
    logic       del_pulse = 1'b0;
    logic       fin_pulse = 1'b0;
    logic       letter_ready = 1'b0;
    logic [9:0] letter_code;
    logic       letter_valid;
    logic [2:0] sym_count;
    logic [1:0] last_sym;
    logic       overflow;

    morse_symbol_capture #(
        .TICK_DIV(TICK_DIV),
        .DOT_MAX (DOT_MAX),
        .DASH_MIN(DASH_MIN),
        .DASH_MAX(DASH_MAX),
        .GAP_MIN (GAP_MIN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .press       (press),
        .del_pulse   (del_pulse),
        .fin_pulse   (fin_pulse),
        .letter_ready(letter_ready),
        .letter_code (letter_code),
        .letter_valid(letter_valid),
        .sym_count   (sym_count),
        .last_sym    (last_sym),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_letters = 0;

    // Model: the letter is just a list of accepted symbols.
    logic [1:0] m_syms[$];
    logic [1:0] m_last = 2'b00;
    bit         m_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] classify(input int ticks);
        if (ticks >= 1 && ticks < DOT_MAX)
            return 2'b10;
        else if (ticks >= DASH_MIN && ticks <= DASH_MAX)
            return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [9:0] exp_code();
        logic [9:0] c = '0;
        for (int i = 0; i < m_syms.size(); i++)
            c[9-2*i -: 2] = m_syms[i];
        return c;
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".count"}, 32'(sym_count), 32'(m_syms.size()));
        check_eq({tag, ".code"}, 32'(letter_code), 32'(exp_code()));
        check_eq({tag, ".last"}, 32'(last_sym), 32'(m_last));
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Hold the key for a whole number of ticks; margins in the chosen values
    // keep the prescaler phase from moving a press across a class boundary.
    task automatic do_press(input int ticks);
        logic [1:0] cls;
        press = 1'b1;
        repeat (4 * ticks) @(negedge clk);
        press = 1'b0;
        @(negedge clk);
        cls    = classify(ticks);
        m_last = cls;
        if (cls != 2'b00) begin
            if (m_syms.size() < 5)
                m_syms.push_back(cls);
            else
                m_ovf = 1'b1;
        end
        check_state("press");
    endtask

    task automatic gap_wait(input int ticks, input bit with_del);
        if (with_del) begin
            del_pulse = 1'b1;
            @(negedge clk);
            del_pulse = 1'b0;
            if (m_syms.size() > 0) begin
                m_syms.delete(m_syms.size() - 1);
                m_ovf = 1'b0;
            end
            check_state("del");
            repeat (4 * ticks - 1) @(negedge clk);
        end else begin
            repeat (4 * ticks) @(negedge clk);
        end
    endtask

    task automatic commit_fin(input bit with_del);
        fin_pulse = 1'b1;
        del_pulse = with_del;
        @(negedge clk);
        fin_pulse = 1'b0;
        del_pulse = 1'b0;
        check_eq("fin.valid", 32'(letter_valid), 32'd1);
        check_state("fin");
    endtask

    task automatic commit_timeout();
        int waited = 0;
        while (!letter_valid && waited < 700) begin
            @(negedge clk);
            waited++;
        end
        check_eq("gap.valid", 32'(letter_valid), 32'd1);
        check_eq("gap.not_early", 32'(waited >= 395), 32'd1);
        check_eq("gap.not_late", 32'(waited <= 405), 32'd1);
        check_state("gap");
    endtask

    task automatic hold_and_release();
        logic [9:0] exp;
        exp = exp_code();
        press     = 1'b1;
        del_pulse = 1'b1;
        fin_pulse = 1'b1;
        @(negedge clk);
        del_pulse = 1'b0;
        fin_pulse = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("hold.valid", 32'(letter_valid), 32'd1);
        check_eq("hold.code", 32'(letter_code), 32'(exp));
        check_eq("hold.count", 32'(sym_count), 32'(m_syms.size()));
        letter_ready = 1'b1;
        @(negedge clk);
        letter_ready = 1'b0;
        m_syms.delete();
        m_ovf = 1'b0;
        check_eq("clear.valid", 32'(letter_valid), 32'd0);
        check_state("clear");
        $display("letter %0d: code=%b released", n_letters, exp);
        n_letters++;
        repeat (6) @(negedge clk);
        press = 1'b0;
        repeat (2) @(negedge clk);
        check_state("held");
    endtask

    function automatic int rand_ticks(input int kind);
        if (kind < 4)
            return int'($urandom_range(3, 18));
        else if (kind < 8)
            return int'($urandom_range(42, 68));
        else if ($urandom_range(0, 1) == 0)
            return int'($urandom_range(23, 37));
        return int'($urandom_range(73, 85));
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset.valid", 32'(letter_valid), 32'd0);
        check_state("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // "A": dot, dash, then gap timeout
        do_press(10);
        gap_wait(30, 1'b0);
        do_press(50);
        commit_timeout();
        hold_and_release();

        // Out-of-class presses store nothing
        do_press(30);
        gap_wait(30, 1'b0);
        do_press(80);
        commit_timeout();
        hold_and_release();

        // Six dots overflow the letter
        for (int i = 0; i < 6; i++) begin
            do_press(8);
            gap_wait(6, 1'b0);
        end
        commit_fin(1'b0);
        hold_and_release();

        // Dash, dot, delete+commit together: delete is dropped
        do_press(55);
        gap_wait(10, 1'b0);
        do_press(5);
        gap_wait(5, 1'b0);
        commit_fin(1'b1);
        hold_and_release();

        // Dot, dash, delete in gap, then commit
        do_press(6);
        gap_wait(10, 1'b0);
        do_press(45);
        gap_wait(10, 1'b1);
        commit_fin(1'b0);
        hold_and_release();

        // Space: commit with nothing entered
        commit_fin(1'b0);
        hold_and_release();

        // Reset in the middle of a press, key held across reset release
        do_press(5);
        gap_wait(5, 1'b0);
        press = 1'b1;
        repeat (4 * 50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_syms.delete();
        m_last = 2'b00;
        m_ovf  = 1'b0;
        check_eq("rst.valid", 32'(letter_valid), 32'd0);
        check_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        press = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rel.valid", 32'(letter_valid), 32'd0);
        check_state("rst_rel");

        // Random letters
        for (int l = 0; l < 10; l++) begin
            int n_sym;
            int ending;
            n_sym  = int'($urandom_range(1, 7));
            ending = int'($urandom_range(0, 2));
            for (int s = 0; s < n_sym; s++) begin
                do_press(rand_ticks(int'($urandom_range(0, 9))));
                if (s < n_sym - 1)
                    gap_wait(int'($urandom_range(3, 30)), $urandom_range(0, 4) == 0);
            end
            if (ending == 0) begin
                gap_wait(int'($urandom_range(3, 30)), $urandom_range(0, 2) == 0);
                commit_fin(1'b0);
            end else if (ending == 1) begin
                gap_wait(int'($urandom_range(3, 30)), 1'b0);
                commit_fin(1'b1);
            end else begin
                commit_timeout();
            end
            hold_and_release();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/morse_symbol_capture.md
MORSE_SYMBOL_CAPTURE -- requirements
Module: morse_symbol_capture

Interface
REQ-001 Parameter TICK_DIV, default 5000: clk cycles per duration tick.
REQ-002 Parameter DOT_MAX, default 2000: press shorter than this many ticks (and at least 1) is a dot.
REQ-003 Parameter DASH_MIN, default 4000: minimum press ticks for a dash.
REQ-004 Parameter DASH_MAX, default 7000: maximum press ticks for a dash.
REQ-005 Parameter GAP_MIN, default 10000: release ticks that auto-commit the letter.
REQ-006 clk  in  1  single system clock; all logic on posedge clk.
REQ-007 rst_n  in  1  reset; asynchronous, active-low.
REQ-008 press  in  1  debounced key level, 1 = pressed.
REQ-009 del_pulse  in  1  one-cycle debounced delete request.
REQ-010 fin_pulse  in  1  one-cycle debounced commit request.
REQ-011 letter_ready  in  1  downstream decoder/cipher accepts letter_code.
REQ-012 letter_code  out  10  five 2-bit symbols, first symbol in [9:8]; 10 = dot, 11 = dash, 00 = empty.
REQ-013 letter_valid  out  1  letter_code is committed and stable.
REQ-014 sym_count  out  3  symbols currently held, 0..5.
REQ-015 last_sym  out  2  class of the last release: 10 = dot, 11 = dash, 00 = rejected or none.
REQ-016 overflow  out  1  a sixth symbol was dropped.

Function
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on wrap; it runs continuously.
REQ-018 Duration counter SHALL be 17 bits, increment on tick, saturate at 131071, and clear on every press edge (rise and fall).
REQ-019 Press edges SHALL be detected against a registered copy of press; only edges start or end a press.
REQ-020 FSM states SHALL be IDLE, PRESS, GAP and HOLD.
REQ-021 IDLE: press rise -> PRESS; fin_pulse -> HOLD, even with sym_count=0 (commits 10'b0 = space).
REQ-022 PRESS: press fall -> classify, then -> GAP; del_pulse and fin_pulse are ignored.
REQ-023 Classification: 1 <= dur < DOT_MAX -> dot; DASH_MIN <= dur <= DASH_MAX -> dash; any other dur -> rejected, no symbol stored.
REQ-024 Accepted symbol SHALL be written to bits [9-2k:8-2k] with k = sym_count, and sym_count incremented; the store is visible the cycle after the fall.
REQ-025 Accepted symbol with sym_count=5 SHALL be dropped and overflow set; sym_count stays 5.
REQ-026 GAP: press rise -> PRESS; dur >= GAP_MIN or fin_pulse -> HOLD.
REQ-027 del_pulse in IDLE or GAP with sym_count>0 SHALL clear slot sym_count-1, decrement sym_count, and clear overflow; with sym_count=0 it has no effect.
REQ-028 fin_pulse and del_pulse in the same GAP cycle: fin_pulse wins, the delete is discarded.
REQ-029 HOLD: letter_valid=1 and letter_code held constant; press, del_pulse and fin_pulse are ignored.
REQ-030 HOLD with letter_ready=1: on the next edge clear letter_code, sym_count and overflow, deassert letter_valid, and go to IDLE.
REQ-031 A press still held when HOLD exits SHALL NOT be captured; only a new rise starts a press.
REQ-032 letter_valid SHALL be 1 exactly while in HOLD; latency from commit cause to letter_valid is 1 cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, prescaler=0, dur=0, letter_code=0, letter_valid=0, sym_count=0, last_sym=00, overflow=0, and the registered press to 0.
REQ-034 Reset mid-press or mid-HOLD SHALL discard all partial or pending data; a press held through reset release is not captured.

Verification (TICK_DIV=4, DOT_MAX=20, DASH_MIN=40, DASH_MAX=70, GAP_MIN=100)
REQ-035 Press 10 ticks, release 30, press 50, release 100+ -> letter_code=10_11_00_00_00 ("A"), letter_valid=1, sym_count=2.
REQ-036 Presses of 30 ticks and 80 ticks -> last_sym=00 for each, sym_count=0, no commit before the gap timeout.
REQ-037 Six dots then fin_pulse -> overflow=1, letter_code=10_10_10_10_10; letter_ready=1 -> next cycle letter_code=0, overflow=0, state IDLE.
REQ-038 Dash, dot, then del_pulse and fin_pulse in the same GAP cycle -> letter_code=11_10_00_00_00 (delete discarded).
REQ-039 Dot, dash, del_pulse in GAP -> sym_count=1, letter_code=10_00_00_00_00; fin_pulse in IDLE with nothing entered -> letter_valid=1 with letter_code=0.
REQ-040 rst_n low during a 50-tick press with press held across reset release -> all outputs 0, no symbol stored when the key is released.
